mergesort_result_reader: RTL

- Consumer end of the sorter output stream. Accepts sorted elements one per handshake and stores them in a local buffer.
- Checks the stream is non-decreasing and counts the elements received.
- Exposes a registered random-access readback port so the testbench or host can dump the sorted list after capture.
- Sits directly downstream of the mergesort core.

---
 rtl/mergesort_result_reader_if.sv | 19 +
 rtl/mergesort_result_reader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mergesort_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : mergesort_result_reader_if
// Description : Element stream from the mergesort core to the result reader.
//               The sorter drives valid/data/last; the reader returns ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface mergesort_result_reader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface
`default_nettype wire

// File: rtl/mergesort_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : mergesort_result_reader
// Description : Captures a sorted element stream into a local buffer, checks
//               that it is non-decreasing, counts elements and offers a
//               registered random-access readback port.
//               Optional macro MERGESORT_READER_CHECKSUM_EN adds a running
//               unsigned sum of accepted elements on the checksum output.
// Revision    : 1.0 - initial release
// ============================================================================
module mergesort_result_reader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  mergesort_result_reader_if.slave in_if,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          count,
  output logic                     order_err,
  output logic [ADDR_W-1:0]        err_index,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data
`ifdef MERGESORT_READER_CHECKSUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Value of count just before the handshake that fills the buffer.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic              ready;
  logic              hs;
  logic              final_hs;
  logic              clear;
  logic [DATA_W-1:0] prev;

  // Buffer sized to the full index space so out-of-range addresses wrap safely.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign in_if.in_ready = ready;
  // Handshake derived from state directly so it has no path through in_ready.
  assign hs       = (state == CAPTURE) && in_if.in_valid;
  assign final_hs = hs && (in_if.in_last || (count == LAST_IDX));
  assign clear    = start && (state != CAPTURE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CAPTURE;
      end
      CAPTURE: begin
        busy  = 1'b1;
        ready = 1'b1;
        if (final_hs) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = CAPTURE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Element count, order check and previous-element tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      order_err <= 1'b0;
      err_index <= '0;
      prev      <= '0;
    end else if (clear) begin
      count     <= '0;
      order_err <= 1'b0;
      err_index <= '0;
    end else if (hs) begin
      count <= count + 1'b1;
      prev  <= in_if.in_data;
      // Only the first descending pair is recorded; the first element has no predecessor.
      if ((count != '0) && (in_if.in_data < prev) && !order_err) begin
        order_err <= 1'b1;
        err_index <= count[ADDR_W-1:0];
      end
    end
  end

`ifdef MERGESORT_READER_CHECKSUM_EN
  // Running sum of accepted elements.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      checksum <= '0;
    else if (clear) checksum <= '0;
    else if (hs)    checksum <= checksum + {{ADDR_W{1'b0}}, in_if.in_data};
  end
`endif

  // Buffer write; contents are not reset.
  always_ff @(posedge clock) begin
    if (hs) mem[count[ADDR_W-1:0]] <= in_if.in_data;
  end

  // Registered readback, active in every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire
